// File: rtl/mem_pkg.sv
// Shared definitions for the memory request queue: FSM state encoding and
// default geometry (queue depth, address width, data width).
// Latency: n/a (package). Backpressure: n/a.
package mem_pkg;

    // Controller-side sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // queue empty, nothing presented
        ST_PRESENT = 2'd1,  // head request driven on rden/wren
        ST_WAIT_RD = 2'd2   // read granted, capturing Dq
    } memq_state_t;

    localparam int MEMQ_DEPTH = 4;
    localparam int MEMQ_AW    = 8;
    localparam int MEMQ_DW    = 8;

    // Ceiling of the stall statistics counter.
    localparam logic [15:0] MEMQ_STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/memq_fifo.sv
// Request storage: circular buffer with extra-MSB pointers for full/empty.
// Latency: push visible at head the cycle after the write; pop advances the head at the edge.
// Backpressure: o_full blocks pushes internally; pops on empty are ignored.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_dat write side;
//        i_pop advance head; o_head_dat current head, o_next_dat entry behind it;
//        o_full/o_empty/o_count occupancy.
module memq_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = MEMQ_DEPTH,
    parameter int W     = 1 + MEMQ_AW + MEMQ_DW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic [W-1:0]             o_next_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [PW-1:0] w_rd_idx;
    logic [PW-1:0] w_rd_idx_nxt;
    logic          w_do_push;
    logic          w_do_pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign w_rd_idx     = r_rd_ptr[PW-1:0];
    assign w_rd_idx_nxt = w_rd_idx + PW'(1);

    assign o_head_dat = r_mem[w_rd_idx];
    // Lets the controller present the following entry in the same edge it pops.
    assign o_next_dat = r_mem[w_rd_idx_nxt];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: contents are only observed through valid pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_dat;
    end

endmodule

// File: rtl/mem_req_queue.sv
// Core-to-memory request queue: buffers read/write requests and presents them in
// order to a controller that grants with a one-cycle acq pulse; returns read data.
// Latency: accepted request presented next cycle at the earliest; read response
// 2 cycles after acq. Backpressure: req_ready low while full (even if popping).
// Ports: CLK, rst_n (async active-low); req_* core request side with req_ready;
//        rden/wren/Address/Din head presentation, acq grant, Dq read data;
//        rsp_valid/rsp_data read response; busy; stall_cnt statistics.
// Optional feature: define MEMQ_STATS_EN to count PRESENT cycles without acq.
module mem_req_queue
    import mem_pkg::*;
#(
    parameter int DEPTH = MEMQ_DEPTH,
    parameter int AW    = MEMQ_AW,
    parameter int DW    = MEMQ_DW
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rden,
    output logic          wren,
    output logic [AW-1:0] Address,
    output logic [DW-1:0] Din,
    input  logic          acq,
    input  logic [DW-1:0] Dq,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic [15:0]   stall_cnt
);
    localparam int EW = 1 + AW + DW;          // {we, addr, wdata}
    localparam int CW = $clog2(DEPTH) + 1;

    memq_state_t   r_state;
    logic          r_rden;
    logic          r_wren;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_busy;

    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_after;
    logic [EW-1:0] w_req_dat;
    logic [EW-1:0] w_head_dat;
    logic [EW-1:0] w_next_dat;
    logic [EW-1:0] w_nxt_head;
    logic          w_push;
    logic          w_pop;
    logic          w_have_next;
    logic          w_head_we;

    assign w_req_dat = {req_we, req_addr, req_wdata};
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    // acq is only meaningful while a head is presented.
    assign w_pop     = (r_state == ST_PRESENT) && acq;
    assign w_head_we = w_head_dat[EW-1];

    memq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst_n    (rst_n),
        .i_push     (w_push),
        .i_dat      (w_req_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_next_dat (w_next_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Occupancy after this edge, including a same-cycle push.
    assign w_cnt_after = w_count - CW'(w_pop) + CW'(w_push);
    assign w_have_next = (w_cnt_after != '0);

    // Entry that will be at the head after this edge. When the queue drains to
    // empty while a push lands, the head is the incoming request itself.
    always_comb begin
        w_nxt_head = w_req_dat;
        if (w_pop) begin
            if (w_count > CW'(1)) w_nxt_head = w_next_dat;
        end else if (!w_empty) begin
            w_nxt_head = w_head_dat;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rden      <= 1'b0;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_have_next) begin
                        r_state <= ST_PRESENT;
                        r_wren  <= w_nxt_head[EW-1];
                        r_rden  <= ~w_nxt_head[EW-1];
                        r_addr  <= w_nxt_head[DW +: AW];
                        r_din   <= w_nxt_head[DW-1:0];
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (acq) begin
                        if (!w_head_we) begin
                            r_state <= ST_WAIT_RD;
                            r_rden  <= 1'b0;
                            r_wren  <= 1'b0;
                            r_busy  <= 1'b1;
                        end else if (w_have_next) begin
                            r_wren  <= w_nxt_head[EW-1];
                            r_rden  <= ~w_nxt_head[EW-1];
                            r_addr  <= w_nxt_head[DW +: AW];
                            r_din   <= w_nxt_head[DW-1:0];
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_rden  <= 1'b0;
                            r_wren  <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    r_rsp_data  <= Dq;
                    r_rsp_valid <= 1'b1;
                    if (w_have_next) begin
                        r_state <= ST_PRESENT;
                        r_wren  <= w_nxt_head[EW-1];
                        r_rden  <= ~w_nxt_head[EW-1];
                        r_addr  <= w_nxt_head[DW +: AW];
                        r_din   <= w_nxt_head[DW-1:0];
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rden  <= 1'b0;
                    r_wren  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rden      = r_rden;
    assign wren      = r_wren;
    assign Address   = r_addr;
    assign Din       = r_din;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

`ifdef MEMQ_STATS_EN
    logic [15:0] r_stall_cnt;

    // Cycles the controller leaves a presented head ungranted; saturates.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if ((r_state == ST_PRESENT) && !acq &&
                     (r_stall_cnt != MEMQ_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter AW, default 8, SHALL set the address width.
REQ-003 Parameter DW, default 8, SHALL set the data width.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  in  1  SHALL mean the core offers a request this cycle.
REQ-007 req_we  in  1  SHALL mean 1=write, 0=read.
REQ-008 req_addr  in  AW  SHALL carry the request address.
REQ-009 req_wdata  in  DW  SHALL carry the write data.
REQ-010 req_ready  out  1  SHALL be high while the queue is not full.
REQ-011 rden, wren  out  1 each  SHALL present the head request to the memory controller.
REQ-012 Address  out  AW and Din  out  DW  SHALL carry the head address and data.
REQ-013 acq  in  1  SHALL be a one-cycle grant pulse from the controller that services the presented head.
REQ-014 Dq  in  DW  SHALL carry read data from the controller.
REQ-015 rsp_valid  out  1 and rsp_data  out  DW  SHALL carry read responses to the core.
REQ-016 busy  out  1  SHALL be high while the queue is non-empty or a read is outstanding.
REQ-017 stall_cnt  out  16  SHALL be the statistics count (see Configuration).

Function
REQ-018 A request SHALL be accepted on a cycle where req_valid and req_ready are both high; entries SHALL leave in FIFO order.
REQ-019 The FSM SHALL have three states: IDLE (empty), PRESENT (head driven), WAIT_RD (read data capture).
REQ-020 IDLE->PRESENT SHALL occur the cycle after the first accept; an accepted entry SHALL never be visible on rden/wren in its accept cycle.
REQ-021 In PRESENT, rden=~we and wren=we of the head SHALL be driven continuously until acq.
REQ-022 On acq with a write head, the queue SHALL pop; the next state SHALL be PRESENT if entries remain, else IDLE.
REQ-023 On acq with a read head, the queue SHALL pop and go to WAIT_RD, with rden/wren low in WAIT_RD.
REQ-024 In WAIT_RD, Dq SHALL be latched into rsp_data, and rsp_valid SHALL pulse high on the next cycle (response 2 cycles after acq); the FSM then goes to PRESENT or IDLE.
REQ-025 acq outside PRESENT SHALL be ignored.
REQ-026 When full, req_ready SHALL be low even if acq pops in the same cycle; push-while-full SHALL be dropped.
REQ-027 A simultaneous push and pop when not full SHALL keep the count unchanged.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH, with full/empty derived from an extra pointer bit.

Reset
REQ-029 On rst_n low, the block SHALL go to IDLE, clear the pointers, and drive rden=wren=rsp_valid=busy=0, Address=Din=rsp_data=0, stall_cnt=0, req_ready=1.
REQ-030 A reset mid-operation SHALL discard all queued and outstanding requests, and no rsp_valid SHALL follow.

Configuration
REQ-031 With macro MEMQ_STATS_EN defined, stall_cnt SHALL increment each cycle in PRESENT without acq and SHALL saturate at 16'hFFFF.
REQ-032 Without MEMQ_STATS_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-033 The FSM state encoding and the default DEPTH/AW/DW constants SHALL live in a shared package mem_pkg.
REQ-034 The storage and pointers SHALL form one sub-module, memq_fifo; the FSM and handshake SHALL stay in mem_req_queue.

Verification
REQ-035 Push write (addr 8'h10, data 8'hA5) -> wren=1, Address=8'h10, Din=8'hA5 the next cycle; acq after 3 cycles -> wren low, busy=0.
REQ-036 Push read of 8'h20, acq, Dq=8'h5C -> rsp_valid pulses 2 cycles after acq with rsp_data=8'h5C.
REQ-037 Push 4 with acq held low -> req_ready=0 and a 5th push dropped; pop 4 -> order preserved, addresses 0,1,2,3.
REQ-038 Full queue with acq and req_valid in the same cycle -> push rejected, count 3.
REQ-039 rst_n low during WAIT_RD -> no rsp_valid, all outputs 0, req_ready=1.
REQ-040 MEMQ_STATS_EN defined, 5 stall cycles before acq -> stall_cnt=5; without the macro, stall_cnt=0.
